sc_speed_ctrl: RTL and testbench

- Upstream stage of the time-tick register counter.
- Converts the player's accelerate/brake buttons and the crash event into a saturating speed value, 0..SPEED_MAX.
- Also produces the registered speed-zone code that the downstream time-tick counter uses to select its tick period.
- Rate of speed change is set by per-mode prescalers running on the 50 MHz clock.

---
 rtl/sc_speed_ctrl_if.sv | 36 +++
 rtl/sc_speed_ctrl.sv | 136 +++++++++++++
 tb/tb_sc_speed_ctrl.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/sc_speed_ctrl_if.sv
// Button/crash inputs and speed/zone outputs of the speed controller.
// The master drives the buttons and the crash pulse. The slave (the controller)
// drives speed, zone, change and crash_out. There is no valid/ready handshake:
// the inputs are sampled on every rising clock edge, and every output is a
// registered level that is valid for the whole following cycle.
interface sc_speed_ctrl_if #(
    parameter int DATAWIDTH = 8
);
    logic                 SC_SpeedCtrl_accel_InLow;
    logic                 SC_SpeedCtrl_brake_InLow;
    logic                 SC_SpeedCtrl_crash_InHigh;
    logic [DATAWIDTH-1:0] SC_SpeedCtrl_speed_OutBUS;
    logic [2:0]           SC_SpeedCtrl_zone_OutBUS;
    logic                 SC_SpeedCtrl_change_OutHigh;
    logic                 SC_SpeedCtrl_crash_OutHigh;

    modport master (
        output SC_SpeedCtrl_accel_InLow,
        output SC_SpeedCtrl_brake_InLow,
        output SC_SpeedCtrl_crash_InHigh,
        input  SC_SpeedCtrl_speed_OutBUS,
        input  SC_SpeedCtrl_zone_OutBUS,
        input  SC_SpeedCtrl_change_OutHigh,
        input  SC_SpeedCtrl_crash_OutHigh
    );

    modport slave (
        input  SC_SpeedCtrl_accel_InLow,
        input  SC_SpeedCtrl_brake_InLow,
        input  SC_SpeedCtrl_crash_InHigh,
        output SC_SpeedCtrl_speed_OutBUS,
        output SC_SpeedCtrl_zone_OutBUS,
        output SC_SpeedCtrl_change_OutHigh,
        output SC_SpeedCtrl_crash_OutHigh
    );
endinterface

// File: rtl/sc_speed_ctrl.sv
// Speed controller: turns the accelerate/brake buttons and the crash pulse into
// a saturating speed (0..SPEED_MAX) plus a registered speed-zone code for the
// time-tick counter. Per-mode prescalers set how fast the speed moves.
module sc_speed_ctrl #(
    parameter int DATAWIDTH   = 8,
    parameter int SPEED_MAX   = 60,
    parameter int PRESC_WIDTH = 24,
    parameter int ACCEL_DIV   = 5000000,
    parameter int BRAKE_DIV   = 1250000,
    parameter int COAST_DIV   = 10000000,
    parameter int CRASH_HOLD  = 50000000
) (
    input  logic                  SC_RegGENERAL_CLOCK_50,
    input  logic                  SC_RegGENERAL_RESET_InHigh,
    sc_speed_ctrl_if.slave        bus_if,
    output logic [2:0]            dbg_state_o
);
    localparam int HOLD_W = (CRASH_HOLD > 1) ? $clog2(CRASH_HOLD) : 1;

    localparam logic [2:0] ST_STOP  = 3'd0;
    localparam logic [2:0] ST_ACCEL = 3'd1;
    localparam logic [2:0] ST_BRAKE = 3'd2;
    localparam logic [2:0] ST_COAST = 3'd3;
    localparam logic [2:0] ST_CRASH = 3'd4;

    localparam logic [PRESC_WIDTH-1:0] ACCEL_LIM = PRESC_WIDTH'(ACCEL_DIV - 1);
    localparam logic [PRESC_WIDTH-1:0] BRAKE_LIM = PRESC_WIDTH'(BRAKE_DIV - 1);
    localparam logic [PRESC_WIDTH-1:0] COAST_LIM = PRESC_WIDTH'(COAST_DIV - 1);
    localparam logic [HOLD_W-1:0]      HOLD_LIM  = HOLD_W'(CRASH_HOLD - 1);
    localparam logic [DATAWIDTH-1:0]   SPD_MAX   = DATAWIDTH'(SPEED_MAX);
    localparam logic [DATAWIDTH-1:0]   SPD_ZERO  = '0;

    logic [2:0]             state_q, state_d;
    logic [PRESC_WIDTH-1:0] presc_q, presc_d, presc_lim;
    logic [HOLD_W-1:0]      hold_q, hold_d;
    logic [DATAWIDTH-1:0]   speed_q, speed_d;
    logic [2:0]             zone_q, zone_d;
    logic                   change_q, change_d;
    logic                   crash_q, crash_d;
    logic                   accel, brake, crash_in, active, strobe;

    assign accel    = ~bus_if.SC_SpeedCtrl_accel_InLow;
    assign brake    = ~bus_if.SC_SpeedCtrl_brake_InLow;
    assign crash_in = bus_if.SC_SpeedCtrl_crash_InHigh;

    // Zone thresholds; codes 5..7 are never produced.
    function automatic logic [2:0] zone_of(input logic [DATAWIDTH-1:0] spd);
        if (spd <= DATAWIDTH'(10)) return 3'd0;
        if (spd <= DATAWIDTH'(18)) return 3'd1;
        if (spd <= DATAWIDTH'(32)) return 3'd2;
        if (spd <= DATAWIDTH'(40)) return 3'd3;
        return 3'd4;
    endfunction

    // Prescaler terminal count for the current mode; a strobe ends each full period.
    always_comb begin
        presc_lim = COAST_LIM;
        active    = 1'b0;
        case (state_q)
            ST_ACCEL: begin presc_lim = ACCEL_LIM; active = 1'b1; end
            ST_BRAKE: begin presc_lim = BRAKE_LIM; active = 1'b1; end
            ST_COAST: begin presc_lim = COAST_LIM; active = 1'b1; end
            default:  begin presc_lim = COAST_LIM; active = 1'b0; end
        endcase
        strobe = active && (presc_q == presc_lim);
    end

    // Next state, speed step and crash hold. Crash beats buttons; in CRASH everything is ignored.
    always_comb begin
        state_d = state_q;
        speed_d = speed_q;
        hold_d  = hold_q;
        if (state_q == ST_CRASH) begin
            if (hold_q == HOLD_LIM) begin
                state_d = ST_STOP;
                hold_d  = '0;
            end else begin
                hold_d = hold_q + 1'b1;
            end
        end else if (crash_in) begin
            state_d = ST_CRASH;
            speed_d = SPD_ZERO;
            hold_d  = '0;
        end else begin
            // The strobe belongs to the mode that just finished its period, so it
            // is applied even if the buttons change on this same edge.
            if (strobe) begin
                if (state_q == ST_ACCEL) begin
                    if (speed_q < SPD_MAX) speed_d = speed_q + 1'b1;
                end else if (speed_q != SPD_ZERO) begin
                    speed_d = speed_q - 1'b1;
                end
            end
            if (brake)                      state_d = ST_BRAKE;
            else if (accel)                 state_d = ST_ACCEL;
            else if (speed_q != SPD_ZERO)   state_d = ST_COAST;
            else                            state_d = ST_STOP;
        end
    end

    // Prescaler restarts on any mode change so a new mode always waits a full period.
    always_comb begin
        if ((state_d != state_q) || !active || strobe) presc_d = '0;
        else                                           presc_d = presc_q + 1'b1;
        change_d = (speed_d != speed_q);
        zone_d   = zone_of(speed_d);
        crash_d  = (state_d == ST_CRASH);
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge SC_RegGENERAL_CLOCK_50 or posedge SC_RegGENERAL_RESET_InHigh) begin
        if (SC_RegGENERAL_RESET_InHigh) begin
            state_q  <= ST_STOP;
            presc_q  <= '0;
            hold_q   <= '0;
            speed_q  <= '0;
            zone_q   <= 3'd0;
            change_q <= 1'b0;
            crash_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            presc_q  <= presc_d;
            hold_q   <= hold_d;
            speed_q  <= speed_d;
            zone_q   <= zone_d;
            change_q <= change_d;
            crash_q  <= crash_d;
        end
    end

    assign bus_if.SC_SpeedCtrl_speed_OutBUS   = speed_q;
    assign bus_if.SC_SpeedCtrl_zone_OutBUS    = zone_q;
    assign bus_if.SC_SpeedCtrl_change_OutHigh = change_q;
    assign bus_if.SC_SpeedCtrl_crash_OutHigh  = crash_q;
    assign dbg_state_o                        = state_q;
endmodule

// File: tb/tb_sc_speed_ctrl.sv
// Bench for sc_speed_ctrl: directed scenarios followed by random button phases,
// all compared cycle by cycle against a behavioural model of the speed rules.
module tb_sc_speed_ctrl;
    localparam int DW         = 8;
    localparam int SPEED_MAX  = 60;
    localparam int ACCEL_DIV  = 4;
    localparam int BRAKE_DIV  = 2;
    localparam int COAST_DIV  = 8;
    localparam int CRASH_HOLD = 10;
    localparam int EW         = DW + 5;

    typedef enum int {M_STOP, M_ACCEL, M_BRAKE, M_COAST, M_CRASH} mode_t;

    logic       clk;
    logic       rst;
    logic [2:0] dbg_state;
    sc_speed_ctrl_if #(.DATAWIDTH(DW)) bus ();

    sc_speed_ctrl #(
        .DATAWIDTH(DW), .SPEED_MAX(SPEED_MAX), .PRESC_WIDTH(24),
        .ACCEL_DIV(ACCEL_DIV), .BRAKE_DIV(BRAKE_DIV),
        .COAST_DIV(COAST_DIV), .CRASH_HOLD(CRASH_HOLD)
    ) dut (
        .SC_RegGENERAL_CLOCK_50    (clk),
        .SC_RegGENERAL_RESET_InHigh(rst),
        .bus_if                    (bus),
        .dbg_state_o               (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, speed=%0d", bus.SC_SpeedCtrl_speed_OutBUS);
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0d expected=%0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    mode_t        m_mode;
    int           m_speed;
    int           m_count;   // clocks spent in the current timed mode
    int           m_left;    // CRASH cycles still to go
    logic [EW-1:0] exp_q[$];

    function automatic int zone_ref(input int s);
        if (s <= 10) return 0;
        if (s <= 18) return 1;
        if (s <= 32) return 2;
        if (s <= 40) return 3;
        return 4;
    endfunction

    function automatic int div_of(input mode_t m);
        case (m)
            M_ACCEL: return ACCEL_DIV;
            M_BRAKE: return BRAKE_DIV;
            default: return COAST_DIV;
        endcase
    endfunction

    task automatic model_reset();
        m_mode  = M_STOP;
        m_speed = 0;
        m_count = 0;
        m_left  = 0;
        exp_q.delete();
    endtask

    task automatic model_edge(input bit acc, input bit brk, input bit crs);
        mode_t nm;
        int    nsp;
        nm  = m_mode;
        nsp = m_speed;
        if (m_mode == M_CRASH) begin
            m_left--;
            nm = (m_left == 0) ? M_STOP : M_CRASH;
        end else if (crs) begin
            nm     = M_CRASH;
            nsp    = 0;
            m_left = CRASH_HOLD;
        end else begin
            if (m_mode != M_STOP) begin
                m_count++;
                if (m_count == div_of(m_mode)) begin
                    m_count = 0;
                    if (m_mode == M_ACCEL) nsp = (m_speed < SPEED_MAX) ? m_speed + 1 : m_speed;
                    else                   nsp = (m_speed > 0) ? m_speed - 1 : 0;
                end
            end
            if (brk)              nm = M_BRAKE;
            else if (acc)         nm = M_ACCEL;
            else if (m_speed > 0) nm = M_COAST;
            else                  nm = M_STOP;
        end
        if (nm != m_mode) m_count = 0;
        exp_q.push_back({DW'(nsp), 3'(zone_ref(nsp)), (nsp != m_speed), (nm == M_CRASH)});
        m_mode  = nm;
        m_speed = nsp;
    endtask

    task automatic compare_outputs();
        logic [EW-1:0] e;
        if (exp_q.size() == 0) begin
            check_eq("scoreboard_empty", 0, 1);
            return;
        end
        e = exp_q.pop_front();
        check_eq("speed",  int'(bus.SC_SpeedCtrl_speed_OutBUS),   int'(e[EW-1:5]));
        check_eq("zone",   int'(bus.SC_SpeedCtrl_zone_OutBUS),    int'(e[4:2]));
        check_eq("change", int'(bus.SC_SpeedCtrl_change_OutHigh), int'(e[1]));
        check_eq("crash",  int'(bus.SC_SpeedCtrl_crash_OutHigh),  int'(e[0]));
    endtask

    // ---------------- driver ----------------
    task automatic tick(input bit acc, input bit brk, input bit crs);
        bus.SC_SpeedCtrl_accel_InLow  = ~acc;
        bus.SC_SpeedCtrl_brake_InLow  = ~brk;
        bus.SC_SpeedCtrl_crash_InHigh = crs;
        @(posedge clk);
        model_edge(acc, brk, crs);
        #1;
        compare_outputs();
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_speed"},  int'(bus.SC_SpeedCtrl_speed_OutBUS),   0);
        check_eq({tag, "_zone"},   int'(bus.SC_SpeedCtrl_zone_OutBUS),    0);
        check_eq({tag, "_change"}, int'(bus.SC_SpeedCtrl_change_OutHigh), 0);
        check_eq({tag, "_crash"},  int'(bus.SC_SpeedCtrl_crash_OutHigh),  0);
    endtask

    // Drive one button pattern until the model reaches a target speed, with a cycle budget.
    task automatic drive_until(input bit acc, input bit brk, input int target, input string tag);
        int n;
        n = 0;
        while (m_speed != target && n < 400) begin
            tick(acc, brk, 1'b0);
            n++;
        end
        check_eq(tag, int'(bus.SC_SpeedCtrl_speed_OutBUS), target);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bus.SC_SpeedCtrl_accel_InLow  = 1'b1;
        bus.SC_SpeedCtrl_brake_InLow  = 1'b1;
        bus.SC_SpeedCtrl_crash_InHigh = 1'b0;
        rst = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        // Accelerate to saturation; no change pulses once at the ceiling.
        repeat (300) tick(1'b1, 1'b0, 1'b0);
        check_eq("sat_speed", int'(bus.SC_SpeedCtrl_speed_OutBUS), 60);
        check_eq("sat_zone",  int'(bus.SC_SpeedCtrl_zone_OutBUS),  4);

        // Both buttons means brake, all the way down to 0.
        drive_until(1'b1, 1'b1, 0, "both_to_zero");
        repeat (6) tick(1'b1, 1'b1, 1'b0);

        // Up to 20, then coast down to 0 and sit in STOP.
        drive_until(1'b1, 1'b0, 20, "accel_to_20");
        drive_until(1'b0, 1'b0, 0, "coast_to_zero");
        repeat (20) tick(1'b0, 1'b0, 1'b0);
        check_eq("stop_speed", int'(bus.SC_SpeedCtrl_speed_OutBUS), 0);

        // Crash at 35 with accel held; a second pulse inside CRASH is ignored.
        drive_until(1'b1, 1'b0, 35, "accel_to_35");
        tick(1'b1, 1'b0, 1'b1);
        check_eq("crash_speed",  int'(bus.SC_SpeedCtrl_speed_OutBUS),   0);
        check_eq("crash_zone",   int'(bus.SC_SpeedCtrl_zone_OutBUS),    0);
        check_eq("crash_change", int'(bus.SC_SpeedCtrl_change_OutHigh), 1);
        check_eq("crash_out",    int'(bus.SC_SpeedCtrl_crash_OutHigh),  1);
        repeat (4) tick(1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b1);
        repeat (30) tick(1'b1, 1'b0, 1'b0);
        check_eq("post_crash_out", int'(bus.SC_SpeedCtrl_crash_OutHigh), 0);

        // Asynchronous reset in the middle of braking at speed 25.
        drive_until(1'b1, 1'b0, 30, "accel_to_30");
        drive_until(1'b0, 1'b1, 25, "brake_to_25");
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("async_rst");
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (8) tick(1'b0, 1'b0, 1'b0);
        check_eq("after_rst_speed", int'(bus.SC_SpeedCtrl_speed_OutBUS), 0);

        // Random button phases with occasional crash pulses.
        for (int p = 0; p < 40; p++) begin
            int  pat;
            int  len;
            bit  acc;
            bit  brk;
            pat = $urandom_range(0, 3);
            len = $urandom_range(1, 60);
            acc = (pat == 1) || (pat == 3);
            brk = (pat == 2) || (pat == 3);
            for (int c = 0; c < len; c++) begin
                tick(acc, brk, ($urandom_range(0, 79) == 0));
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
